// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Definitions shared by both ends of the 4-channel serial TDM link
// (tdm_demux4 receiver and the matching transmitter).
//
// Contents:
//   tdm_state_e  - receiver alignment state (HUNT = 1'b0, SYNC = 1'b1)
//   NUM_SLOTS    - slots per frame (fixed at 4)
//   SLOT_IDX_W   - width of the slot counter (2 bits)
//   slot_len()   - serial bits per slot for a given data width
//
// Configuration macro: TDM_DEMUX_PARITY_EN
//   When defined, each slot carries one trailing even-parity bit, so a slot is
//   WIDTH+1 bits long. When undefined, a slot is exactly WIDTH bits long.
// -----------------------------------------------------------------------------
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } tdm_state_e;

    localparam int NUM_SLOTS  = 4;
    localparam int SLOT_IDX_W = 2;

    // Number of serial bits that make up one slot on the line.
    function automatic int slot_len(input int width);
`ifdef TDM_DEMUX_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage : tdm_pkg

// File: rtl/tdm_slot_shifter.sv
// -----------------------------------------------------------------------------
// tdm_slot_shifter
// Serial-to-parallel shifter for one TDM slot. Bits arrive MSB first and are
// shifted into the LSB. A bit counter tracks the position inside the slot.
//
// Parameters:
//   LEN        - serial bits per slot (>= 2)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   din        in   serial data bit
//   en         in   shift din in and advance the bit counter
//   load       in   restart: din becomes bit 0 of a new slot (counter -> 1)
//   clear      in   drop any partial slot (shift register and counter -> 0)
//   word_done  out  the bit being shifted in this cycle completes the slot
//   word       out  full slot word including the current din, {history, din}
//   at_bit0    out  counter is at bit 0 (next bit starts a new slot)
//
// Priority when several controls are high: clear, then load, then en.
// -----------------------------------------------------------------------------
module tdm_slot_shifter
    import tdm_pkg::*;
#(
    parameter int LEN = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           din,
    input  logic           en,
    input  logic           load,
    input  logic           clear,
    output logic           word_done,
    output logic [LEN-1:0] word,
    output logic           at_bit0
);

    localparam int               CNT_W = $clog2(LEN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

    // Only LEN-1 bits of history are needed: the last bit of a slot is
    // taken straight from din on the completing edge.
    logic [LEN-2:0]   shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    assign word      = {shift_q, din};
    assign word_done = en && (cnt_q == LAST);
    assign at_bit0   = (cnt_q == '0);

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (load) begin
            shift_d = (LEN - 1)'(din);
            cnt_d   = CNT_W'(1);
        end else if (en) begin
            shift_d = word[LEN-2:0];
            cnt_d   = word_done ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : tdm_slot_shifter

// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4
// Receive side of the 4-channel serial TDM link. Finds frame alignment from
// frame_sync, deserializes each slot (MSB first) and publishes the word on a
// per-channel output register with a one-cycle valid strobe.
//
// Parameters:
//   WIDTH       - data bits per slot (2..32)
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   din         in   serial data bit (sampled only when en=1)
//   en          in   bit-valid qualifier; en=0 cycles are ignored entirely
//   frame_sync  in   high with the first bit of slot 0 (sampled when en=1)
//   dout        out  channel words, slot k at dout[k*WIDTH +: WIDTH]
//   ch_valid    out  one-hot one-cycle strobe when slot k's word updates
//   frame_done  out  one-cycle pulse coincident with ch_valid[3]
//   locked      out  high while aligned (state SYNC)
//   sync_err    out  one-cycle pulse on an alignment violation
//   par_err     out  (TDM_DEMUX_PARITY_EN only) per-slot parity failure,
//                    pulses together with ch_valid[k]
//
// Configuration macro: TDM_DEMUX_PARITY_EN adds a trailing even-parity bit to
// every slot and the par_err port. dout is updated even on a parity error.
// -----------------------------------------------------------------------------
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       din,
    input  logic                       en,
    input  logic                       frame_sync,
    output logic [NUM_SLOTS*WIDTH-1:0] dout,
    output logic [NUM_SLOTS-1:0]       ch_valid,
    output logic                       frame_done,
    output logic                       locked,
    output logic                       sync_err
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic [NUM_SLOTS-1:0]       par_err
`endif
);

    localparam int                    LEN       = slot_len(WIDTH);
    localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = SLOT_IDX_W'(NUM_SLOTS - 1);

    tdm_state_e                 state_q,      state_d;
    logic [SLOT_IDX_W-1:0]      slot_q,       slot_d;
    logic [NUM_SLOTS*WIDTH-1:0] dout_q,       dout_d;
    logic [NUM_SLOTS-1:0]       ch_valid_q,   ch_valid_d;
    logic                       frame_done_q, frame_done_d;
    logic                       sync_err_q,   sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
    logic [NUM_SLOTS-1:0]       par_err_q,    par_err_d;
`endif

    logic           sh_en;
    logic           sh_load;
    logic           sh_clear;
    logic           sh_word_done;
    logic [LEN-1:0] sh_word;
    logic           sh_at_bit0;

    logic           in_sync;
    logic           at_frame_start;

    assign in_sync        = (state_q == SYNC);
    assign at_frame_start = (slot_q == '0) && sh_at_bit0;

    // Shifter controls depend only on registered state and inputs, so the
    // word_done feedback into the FSM below never forms a combinational loop.
    //   normal shift : in SYNC, frame_sync agrees with the frame position
    //   load         : frame_sync seen in HUNT, or early frame_sync in SYNC
    //   clear        : frame_sync missing where a frame must start
    assign sh_en    = en && in_sync && (frame_sync == at_frame_start);
    assign sh_load  = en && frame_sync && (!in_sync || !at_frame_start);
    assign sh_clear = en && in_sync && !frame_sync && at_frame_start;

    tdm_slot_shifter #(
        .LEN       (LEN)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .en        (sh_en),
        .load      (sh_load),
        .clear     (sh_clear),
        .word_done (sh_word_done),
        .word      (sh_word),
        .at_bit0   (sh_at_bit0)
    );

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        dout_d       = dout_q;
        ch_valid_d   = '0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        par_err_d    = '0;
`endif

        case (state_q)
            HUNT: begin
                // The bit carrying frame_sync is bit 0 of slot 0.
                if (sh_load) begin
                    state_d = SYNC;
                    slot_d  = '0;
                end
            end
            SYNC: begin
                if (sh_load) begin
                    // Early frame marker: drop the partial slot and realign
                    // on this bit without leaving SYNC.
                    sync_err_d = 1'b1;
                    slot_d     = '0;
                end else if (sh_clear) begin
                    // Missing frame marker: lose lock and discard the bit.
                    sync_err_d = 1'b1;
                    state_d    = HUNT;
                    slot_d     = '0;
                end else if (sh_word_done) begin
                    // Data sits in the top WIDTH bits; the parity bit, when
                    // present, is the last bit received.
                    dout_d[slot_q*WIDTH +: WIDTH] = sh_word[LEN-1 -: WIDTH];
                    ch_valid_d[slot_q]            = 1'b1;
                    frame_done_d                  = (slot_q == LAST_SLOT);
                    slot_d                        = slot_q + SLOT_IDX_W'(1);
`ifdef TDM_DEMUX_PARITY_EN
                    par_err_d[slot_q]             = ^sh_word;
`endif
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            slot_q       <= '0;
            dout_q       <= '0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            dout_q       <= dout_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q    <= par_err_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign locked     = in_sync;
    assign sync_err   = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign par_err    = par_err_q;
`endif

endmodule : tdm_demux4

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive side of the 4-channel serial time-division link.
- A transmitter rotates a 4:1 mux select across four slots and shifts each slot's WIDTH-bit word out serially, MSB first, with a frame marker on the first bit of slot 0.
- This block finds frame alignment, deserializes each slot, and presents the word on a per-channel output register with a one-cycle valid strobe.
- Sits between the serial line synchronizer and the per-channel consumers.

Parameters:
- WIDTH, 8, data bits per slot (2..32).
- NUM_SLOTS, 4, slots per frame; fixed at 4, with a 2-bit slot counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  serial data bit, sampled only when en=1.
- en  input  1  bit-valid qualifier; en=0 cycles are ignored entirely.
- frame_sync  input  1  high with the first bit of slot 0; sampled only when en=1.
- dout  output  4*WIDTH  channel words; slot k is at dout[k*WIDTH +: WIDTH].
- ch_valid  output  4  one-hot, one-cycle strobe when slot k's word is updated.
- frame_done  output  1  one-cycle pulse, coincident with ch_valid[3].
- locked  output  1  high while the state is SYNC.
- sync_err  output  1  one-cycle pulse on an alignment violation.

Behaviour:
- Reset is asynchronous and active-low: clk rising edge, rst_n low.
- Reset values: dout=0, ch_valid=0, frame_done=0, locked=0, sync_err=0. Internally, state=HUNT, bit_cnt=0, slot_cnt=0, shift register=0.
- All outputs are registered.
- States:
  - HUNT: ignore din until a cycle with en=1 and frame_sync=1. That bit is taken as bit 0 of slot 0 and shifted in, bit_cnt=1, slot_cnt=0, next state SYNC. No sync_err is raised in HUNT.
  - SYNC: on each en=1 cycle, shift din into the LSB of the shift register and increment bit_cnt.
- Slot completion:
  - On the en cycle carrying bit WIDTH-1, at that clock edge: dout slot slot_cnt = {shift[WIDTH-2:0], din}, ch_valid[slot_cnt]=1, bit_cnt=0, slot_cnt increments (wrapping 3→0).
  - Latency is one clock from the last bit's sampling edge to the strobe.
- frame_done=1 on the same edge as ch_valid[3]. Strobes are always single-cycle, even if en stays high.
- Alignment checks in SYNC, evaluated only when en=1:
  - frame_sync=1 while not at (slot 0, bit 0): sync_err=1, the partial slot is discarded (no ch_valid), and the block realigns immediately. The current bit becomes bit 0 of slot 0 (bit_cnt=1, slot_cnt=0) and the state stays SYNC.
  - frame_sync=0 at (slot 0, bit 0): sync_err=1, the bit is discarded, and the state goes to HUNT (locked falls on that edge).
- Gaps in en of any length do not disturb counters or state.
- dout holds its last value until that slot is overwritten. dout is not cleared by HUNT or by sync_err.
- If rst_n asserts mid-frame, everything returns to reset values at once. Partial words are lost and no strobe is issued.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- When defined:
  - Each slot carries WIDTH data bits followed by one even-parity bit, so the slot length is WIDTH+1.
  - An extra output port, par_err (4 bits), is added. par_err[k] pulses together with ch_valid[k] when the XOR of the data and parity bits is 1.
  - dout is still updated on a parity error.
- When undefined:
  - The slot length is WIDTH.
  - There is no par_err port and no parity logic.

Decomposition:
- Shared package tdm_pkg holds:
  - the state encoding (HUNT=1'b0, SYNC=1'b1);
  - NUM_SLOTS=4 and SLOT_IDX_W=2;
  - a slot-length function that returns WIDTH or WIDTH+1 depending on TDM_DEMUX_PARITY_EN.
- The transmitter shares the same package.
- One natural sub-module, tdm_slot_shifter. It holds the WIDTH-bit shift register and bit counter, with en and clear inputs, and outputs word_done and word.
- tdm_demux4 keeps the FSM, slot counter, output registers and checks.

Test Plan (WIDTH=8, en=1 continuously unless stated):
1. Frame with frame_sync on its first bit, slots 0xA5, 0x3C, 0xFF, 0x01 → ch_valid 0001, 0010, 0100, 1000 on cycles 8, 16, 24, 32 after the first bit; dout=0x01FF3CA5; frame_done with the 4th strobe; locked=1 from cycle 1.
2. Same frame with en toggling 1/0 every cycle → identical dout and strobe order; each strobe appears one clock after the 8th qualified bit.
3. Second frame sent without frame_sync on its first bit → sync_err pulses once; locked=0; no ch_valid until the next frame_sync.
4. frame_sync asserted at slot 2, bit 3 → sync_err pulses; no ch_valid[2]; the next 8 bits of 0x77 produce ch_valid[0] with dout[7:0]=0x77.
5. rst_n pulled low for 1 cycle at slot 1, bit 4 → all outputs read 0 asynchronously; locked=0; re-lock on the next frame_sync.
6. With TDM_DEMUX_PARITY_EN: slot 0 = 0x03 with parity 1 → par_err[0]=1 together with ch_valid[0]; slot 0 = 0x03 with parity 0 → par_err=0.
